// File: rtl/vector_seq.sv
// Vector-image ROM walker: streams {x,y,line,pos} points to the beam driver with a settle dwell.
// Define VECTOR_SEQ_LOOP_EN to make the end marker restart the shape instead of returning to idle.
//
// state      | meaning
// st_idle    | waiting for start
// st_fetch   | decode rom_data at rom_addr (end marker, stop, watchdog checks)
// st_present | point on pt_*, waiting for pt_ready
// st_dwell   | analog settle down-count before next fetch
module vector_seq #(
    parameter int ADDRESSWIDTH = 16,
    parameter int DATAWIDTH    = 18,
    parameter int DWELL        = 4,
    parameter int MAX_PTS      = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [ADDRESSWIDTH-1:0] base_addr,
    output logic [ADDRESSWIDTH-1:0] rom_addr,
    input  logic [DATAWIDTH-1:0]    rom_data,
    output logic [7:0]              pt_x,
    output logic [7:0]              pt_y,
    output logic                    pt_beam,
    output logic                    pt_valid,
    input  logic                    pt_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int cnt_w   = $clog2(MAX_PTS + 1);
    localparam int dwell_w = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [ADDRESSWIDTH-1:0] addr_last  = '1;
    localparam logic [cnt_w-1:0]        cnt_max    = cnt_w'(MAX_PTS);
    localparam logic [dwell_w-1:0]      dwell_load = (DWELL > 0) ? dwell_w'(DWELL - 1) : '0;

    typedef enum logic [1:0] {
        st_idle,
        st_fetch,
        st_present,
        st_dwell
    } state_t;

    state_t               state;
    logic [cnt_w-1:0]     pt_cnt;
    logic [dwell_w-1:0]   dwell_cnt;
`ifdef VECTOR_SEQ_LOOP_EN
    logic [ADDRESSWIDTH-1:0] base_q;
`endif

    logic word_line;
    logic word_pos;
    logic end_mark;

    assign word_line = rom_data[1];
    assign word_pos  = rom_data[0];
    assign end_mark  = word_line & word_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= st_idle;
            rom_addr  <= '0;
            pt_x      <= '0;
            pt_y      <= '0;
            pt_beam   <= 1'b0;
            pt_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pt_cnt    <= '0;
            dwell_cnt <= '0;
`ifdef VECTOR_SEQ_LOOP_EN
            base_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                st_idle: begin
                    if (start) begin
                        rom_addr <= base_addr;
`ifdef VECTOR_SEQ_LOOP_EN
                        base_q   <= base_addr;
`endif
                        pt_cnt   <= '0;
                        busy     <= 1'b1;
                        state    <= st_fetch;
                    end
                end

                // Priority: stop, then watchdog, then end marker, then a real point.
                st_fetch: begin
                    if (stop) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= st_idle;
                    end else if (pt_cnt == cnt_max) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= st_idle;
                    end else if (end_mark) begin
                        done <= 1'b1;
`ifdef VECTOR_SEQ_LOOP_EN
                        rom_addr <= base_q;
                        pt_cnt   <= '0;
                        state    <= st_fetch;
`else
                        busy  <= 1'b0;
                        state <= st_idle;
`endif
                    end else begin
                        pt_x     <= rom_data[17:10];
                        pt_y     <= rom_data[9:2];
                        pt_beam  <= word_line;
                        pt_valid <= 1'b1;
                        state    <= st_present;
                    end
                end

                st_present: begin
                    if (pt_ready) begin
                        pt_valid <= 1'b0;
                        pt_cnt   <= pt_cnt + 1'b1;
                        if (rom_addr == addr_last) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= st_idle;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            if (DWELL == 0) begin
                                state <= st_fetch;
                            end else begin
                                dwell_cnt <= dwell_load;
                                state     <= st_dwell;
                            end
                        end
                    end
                end

                st_dwell: begin
                    if (dwell_cnt == '0) begin
                        state <= st_fetch;
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= st_idle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_seq.sv
// Scoreboard bench for vector_seq: a shape-walking reference model queues expected points/done/err.
module tb_vector_seq;

    localparam int DWELL   = 4;
    localparam int MAX_PTS = 8;
`ifdef VECTOR_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] rom_addr;
    logic [17:0] rom_data;
    logic [7:0]  pt_x, pt_y;
    logic        pt_beam, pt_valid;
    logic        pt_ready = 1'b1;
    logic        busy, done, err;

    logic [17:0] mem [0:65535];
    assign rom_data = mem[rom_addr];

    vector_seq #(
        .ADDRESSWIDTH(16),
        .DATAWIDTH(18),
        .DWELL(DWELL),
        .MAX_PTS(MAX_PTS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .base_addr(base_addr),
        .rom_addr(rom_addr), .rom_data(rom_data), .pt_x(pt_x), .pt_y(pt_y),
        .pt_beam(pt_beam), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 0 point, 1 done, 2 err
        logic [7:0] x;
        logic [7:0] y;
        logic       beam;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  hs_total = 0;
    bit  rdy_rand = 1'b0;
    bit  rdy_force = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [17:0] pw(input int x, input int y, input bit beam);
        return {8'(x), 8'(y), beam ? 2'b10 : 2'b01};
    endfunction

    function automatic logic [17:0] rand_pt();
        return pw(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
    endfunction

    localparam logic [17:0] ENDW = 18'h00003;

    // Walks the ROM as the shape rules describe and queues what the beam driver should see.
    task automatic model_run(input logic [15:0] base, input int stop_after);
        int   a = int'(base);
        int   k = 0;
        int   total = 0;
        ev_t  e;
        logic [17:0] w;
        for (int guard = 0; guard < 10000; guard++) begin
            if (stop_after >= 0 && total == stop_after) begin
                e = '{1, 8'd0, 8'd0, 1'b0}; exp_q.push_back(e); return;
            end
            if (k == MAX_PTS) begin
                e = '{2, 8'd0, 8'd0, 1'b0}; exp_q.push_back(e); return;
            end
            w = mem[a];
            if (w[1] && w[0]) begin
                e = '{1, 8'd0, 8'd0, 1'b0}; exp_q.push_back(e);
                if (!LOOP) return;
                a = int'(base);
                k = 0;
            end else begin
                e = '{0, w[17:10], w[9:2], w[1]};
                exp_q.push_back(e);
                total++;
                k++;
                if (a == 65535) begin
                    e = '{2, 8'd0, 8'd0, 1'b0}; exp_q.push_back(e); return;
                end
                a++;
            end
        end
    endtask

    always @(posedge clk) begin
        #2;
        pt_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    ev_t         mon_e;
    logic        prev_stall = 1'b0;
    logic [7:0]  px, py;
    logic        pb;
    logic [15:0] pa;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 32'(pt_valid), 32'd1);
                check("hold_x", 32'(pt_x), 32'(px));
                check("hold_y", 32'(pt_y), 32'(py));
                check("hold_beam", 32'(pt_beam), 32'(pb));
                check("hold_addr", 32'(rom_addr), 32'(pa));
            end
            if (pt_valid && pt_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_point", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("point_kind", 32'(mon_e.kind), 32'd0);
                    check("point_x", 32'(pt_x), 32'(mon_e.x));
                    check("point_y", 32'(pt_y), 32'(mon_e.y));
                    check("point_beam", 32'(pt_beam), 32'(mon_e.beam));
                end
                hs_total++;
            end
            if (done) begin
                if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("done_kind", 32'(mon_e.kind), 32'd1);
                end
            end
            if (err) begin
                if (exp_q.size() == 0) check("unexpected_err", 32'd1, 32'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("err_kind", 32'(mon_e.kind), 32'd2);
                end
            end
            prev_stall = pt_valid && !pt_ready;
            px = pt_x; py = pt_y; pb = pt_beam; pa = rom_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] b);
        base_addr = b;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 2000) begin tick(1); n++; end
        check(nm, 32'(busy), 32'd0);
    endtask

    task automatic drain(input string nm);
        tick(3);
        check(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_point(input int hs0, input int idx);
        int n = 0;
        while (!(pt_valid && (hs_total - hs0) == idx) && busy && n < 2000) begin
            tick(1); n++;
        end
        check("stop_point_reached", 32'(pt_valid), 32'd1);
    endtask

    task automatic run_shape(input logic [15:0] b, input int stop_after, input bit timing);
        int hs0;
        int lat;
        int sp;
        model_run(b, stop_after);
        hs0 = hs_total;
        if (stop_after == 0) stop = 1'b1;
        do_start(b);
        if (timing) begin
            lat = 1;
            while (!pt_valid && lat < 10) begin tick(1); lat++; end
            check("first_latency", 32'(lat), 32'd2);
            sp = 0;
            while (pt_valid && sp < 50) begin tick(1); sp++; end
            while (!pt_valid && sp < 50) begin tick(1); sp++; end
            check("point_spacing", 32'(sp), 32'(2 + DWELL));
        end
        if (stop_after > 0) begin
            wait_point(hs0, stop_after - 1);
            stop = 1'b1;
        end
        wait_idle("idle_timeout");
        stop = 1'b0;
        drain("leftover_events");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int hs0;
        int n;
        int len;
        int sa;
        logic [15:0] b;

        for (int i = 0; i < 65536; i++) mem[i] = rand_pt();

        #2 rst_n = 1'b0;
        #1;
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_pt_xy", {16'd0, pt_x, pt_y}, 32'd0);
        check("rst_flags", {27'd0, pt_beam, pt_valid, busy, done, err}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // T1: single shot with timing
        mem[0] = pw(10, 20, 0);
        mem[1] = pw(30, 40, 1);
        mem[2] = 18'({8'd30, 8'd40, 2'b11});
        rdy_rand = 1'b0; rdy_force = 1'b1;
        tick(1);
        run_shape(16'd0, LOOP ? 2 : -1, 1'b1);

        // T2: backpressure on point 2
        model_run(16'd0, LOOP ? 2 : -1);
        hs0 = hs_total;
        do_start(16'd0);
        n = 0;
        while ((hs_total - hs0) < 1 && n < 200) begin tick(1); n++; end
        rdy_force = 1'b0;
        n = 0;
        while (!pt_valid && n < 200) begin tick(1); n++; end
        check("bp_point2_valid", 32'(pt_valid), 32'd1);
        tick(7);
        check("bp_addr_held", 32'(rom_addr), 32'd1);
        check("bp_x_held", 32'(pt_x), 32'd30);
        if (LOOP) stop = 1'b1;
        rdy_force = 1'b1;
        wait_idle("bp_idle_timeout");
        stop = 1'b0;
        drain("bp_leftover");

        // T3: stop while point 1 presented
        run_shape(16'd0, 1, 1'b0);
        // start and stop together: start wins, no points, done
        run_shape(16'd0, 0, 1'b0);

        // T4: watchdog, no end marker
        for (int i = 100; i < 130; i++) mem[i] = rand_pt();
        rdy_rand = 1'b1;
        run_shape(16'd100, -1, 1'b0);

        // Address wrap at the top of the ROM
        mem[16'hFFFE] = pw(1, 2, 1);
        mem[16'hFFFF] = pw(3, 4, 0);
        run_shape(16'hFFFE, -1, 1'b0);
        check("wrap_addr_held", 32'(rom_addr), 32'hFFFF);

        // T5: reset while a point is presented, then the frame shape
        rdy_rand = 1'b0; rdy_force = 1'b0;
        tick(1);
        model_run(16'd0, LOOP ? 2 : -1);
        do_start(16'd0);
        n = 0;
        while (!pt_valid && n < 50) begin tick(1); n++; end
        check("t5_presenting", 32'(pt_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(pt_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_addr", 32'(rom_addr), 32'd0);
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        rdy_force = 1'b1;
        tick(2);
        mem[42] = pw(0, 0, 0);
        mem[43] = pw(254, 0, 1);
        mem[44] = pw(254, 254, 1);
        mem[45] = pw(0, 254, 1);
        mem[46] = pw(0, 0, 1);
        mem[47] = ENDW;
        run_shape(16'd42, LOOP ? 5 : -1, 1'b0);

`ifdef VECTOR_SEQ_LOOP_EN
        // T6: continuous refresh of the T1 shape, ended by stop
        run_shape(16'd0, 5, 1'b0);
`endif

        // Randomized shapes with random backpressure and occasional stop
        rdy_rand = 1'b1;
        for (int it = 0; it < 20; it++) begin
            b = 16'($urandom_range(1000, 60000));
            len = int'($urandom_range(0, 6));
            for (int j = 0; j < len; j++) mem[b + 16'(j)] = rand_pt();
            mem[b + 16'(len)] = ENDW;
            if (LOOP || $urandom_range(0, 3) == 0) sa = int'($urandom_range(0, len));
            else sa = -1;
            run_shape(b, sa, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
